ps2_mouse_transmitter: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xFF reset, 0xF4 enable streaming) to the mouse.

---
 rtl/ps2_mouse_transmitter.sv | 149 ++++++++++++++
 tb/tb_ps2_mouse_transmitter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_transmitter.sv
// Host-to-device PS/2 command transmitter: clock inhibit, request-to-send,
// 8 data bits LSB-first, odd parity, stop via pull-up, then device ACK check.
module ps2_mouse_transmitter #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_WIDTH      = 21
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT,
  output logic       DATA_MOUSE_OUT_EN,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic       ERROR,
  output logic [2:0] STATE_DBG
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_ACK, S_DONE, S_ERR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] INHIBIT_LAST = CNT_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [8:0]           shift, shift_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic                 data_bit, data_bit_n;
  logic                 clk_s1, clk_s2, clk_prev;
  logic                 data_s1, data_s2;
  logic                 fe;
  logic                 timeout;

  // Pads idle high, so the synchronizer resets to the released level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= CLK_MOUSE_IN;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= DATA_MOUSE_IN;
      data_s2  <= data_s1;
    end
  end

  assign fe      = clk_prev & ~clk_s2;
  assign timeout = (cnt == TIMEOUT_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      data_bit <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      data_bit <= data_bit_n;
    end
  end

  // Request handshake: SEND_BYTE acts as valid and ~BUSY as ready; a request
  // is taken only in a cycle where both hold, and BYTE_TO_SEND is latched then.
  always_comb begin
    state_n           = state;
    cnt_n             = cnt;
    shift_n           = shift;
    bit_cnt_n         = bit_cnt;
    data_bit_n        = data_bit;
    CLK_MOUSE_OUT_EN  = 1'b0;
    DATA_MOUSE_OUT    = 1'b1;
    DATA_MOUSE_OUT_EN = 1'b0;
    BUSY              = 1'b0;
    BYTE_SENT         = 1'b0;
    ERROR             = 1'b0;
    case (state)
      S_IDLE: begin
        if (SEND_BYTE) begin
          shift_n = {~^BYTE_TO_SEND, BYTE_TO_SEND};
          cnt_n   = '0;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        CLK_MOUSE_OUT_EN = 1'b1;
        BUSY             = 1'b1;
        if (cnt == INHIBIT_LAST) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = S_RTS;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RTS, S_SEND, S_WAIT_ACK: begin
        BUSY = 1'b1;
        if (state == S_RTS) begin
          DATA_MOUSE_OUT_EN = 1'b1;
          DATA_MOUSE_OUT    = 1'b0;
        end else if (state == S_SEND) begin
          DATA_MOUSE_OUT_EN = 1'b1;
          DATA_MOUSE_OUT    = data_bit;
        end
        // Counter saturates at the timeout value, which also wins over an FE.
        if (!timeout) cnt_n = cnt + 1'b1;
        if (timeout) begin
          state_n = S_ERR;
        end else if (fe) begin
          if (state == S_WAIT_ACK) begin
            state_n = data_s2 ? S_ERR : S_DONE;
          end else if (state == S_SEND && bit_cnt == 4'd9) begin
            state_n = S_WAIT_ACK;
          end else begin
            data_bit_n = shift[0];
            shift_n    = {1'b0, shift[8:1]};
            bit_cnt_n  = bit_cnt + 4'd1;
            state_n    = S_SEND;
          end
        end
      end
      S_DONE: begin
        BYTE_SENT = 1'b1;
        state_n   = S_IDLE;
      end
      S_ERR: begin
        ERROR   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign STATE_DBG = state;

endmodule

// File: tb/tb_ps2_mouse_transmitter.sv
// Bench for ps2_mouse_transmitter: a device model clocks the pads, and a
// phase/edge-count model of the frame is compared against the outputs every cycle.
module tb_ps2_mouse_transmitter;

  localparam int INHIBIT = 10000;
  localparam int TIMEOUT = 500;
  localparam int HALF    = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       send_byte = 1'b0;
  logic [7:0] byte_to_send = 8'h00;
  logic       clk_en, data_out, data_en, busy, byte_sent, error;
  logic [2:0] state_dbg;
  logic       clk_pad, data_pad;
  logic [5:0] outs;

  int vectors = 0;
  int miscompares = 0;
  int sent_total = 0;
  int err_total = 0;

  // Wired-AND open-drain pads.
  assign clk_pad  = dev_clk & ~clk_en;
  assign data_pad = dev_data & (data_en ? data_out : 1'b1);
  assign outs     = {clk_en, data_en, data_out, busy, byte_sent, error};

  ps2_mouse_transmitter #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_WIDTH(21)
  ) dut (
    .CLK(clk),
    .RESET(reset),
    .CLK_MOUSE_IN(clk_pad),
    .DATA_MOUSE_IN(data_pad),
    .SEND_BYTE(send_byte),
    .BYTE_TO_SEND(byte_to_send),
    .CLK_MOUSE_OUT_EN(clk_en),
    .DATA_MOUSE_OUT(data_out),
    .DATA_MOUSE_OUT_EN(data_en),
    .BUSY(busy),
    .BYTE_SENT(byte_sent),
    .ERROR(error),
    .STATE_DBG(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_INHIBIT, M_FRAME, M_DONE, M_ERR} m_phase_t;
  m_phase_t   m_phase = M_IDLE;
  int         m_t = 0;
  int         m_fe = 0;
  logic [7:0] m_byte = 8'h00;
  logic       p1 = 1'b1, p2 = 1'b1, p3 = 1'b1;
  logic       d1 = 1'b1, d2 = 1'b1;
  logic       m_edge, m_ack;

  // An FE acts 3 edges after the pad falls: pad low two samples ago, high three ago.
  always @(posedge clk) begin
    m_edge = p3 && !p2;
    m_ack  = d2;
    p3 = p2; p2 = p1; p1 = dev_clk;
    d2 = d1; d1 = dev_data;
    if (reset) begin
      m_phase = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE: if (send_byte) begin
          m_byte  = byte_to_send;
          m_t     = 0;
          m_phase = M_INHIBIT;
        end
        M_INHIBIT: begin
          m_t++;
          if (m_t == INHIBIT) begin
            m_phase = M_FRAME;
            m_t     = 0;
            m_fe    = 0;
          end
        end
        M_FRAME: begin
          m_t++;
          if (m_t == TIMEOUT) m_phase = M_ERR;
          else if (m_edge) begin
            m_fe++;
            if (m_fe == 11) m_phase = m_ack ? M_ERR : M_DONE;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // {clk_en, data_en, data_out, busy, byte_sent, error}
  function automatic logic [5:0] model_out();
    case (m_phase)
      M_IDLE:    return 6'b001000;
      M_INHIBIT: return 6'b101100;
      M_FRAME: begin
        if (m_fe == 0) return 6'b010100;
        if (m_fe <= 8) return {2'b01, m_byte[m_fe-1], 3'b100};
        if (m_fe == 9) return {2'b01, ~^m_byte, 3'b100};
        return 6'b001100;
      end
      M_DONE:    return 6'b001010;
      default:   return 6'b001001;
    endcase
  endfunction

  always @(negedge clk) begin
    check("outputs", {26'd0, outs}, {26'd0, model_out()});
    if (byte_sent) sent_total++;
    if (error) err_total++;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    send_byte    = 1'b1;
    byte_to_send = b;
    @(negedge clk);
    send_byte = 1'b0;
  endtask

  // Counts cycles with the clock held low; optionally pokes a request while busy.
  task automatic wait_inhibit(output int n, input bit poke);
    n = 0;
    while (clk_en && n < 2 * INHIBIT) begin
      n++;
      if (poke && n == 5) begin
        send_byte    = 1'b1;
        byte_to_send = 8'h00;
      end else if (poke && n == 6) begin
        send_byte = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Device clocks n_fe falling edges; data/enable seen just before each edge is
  // recorded. The last edge leaves the clock low.
  task automatic device(input int n_fe, input logic ack,
                        output logic [10:0] seen, output logic [10:0] seen_en);
    seen    = '1;
    seen_en = '0;
    for (int k = 0; k < n_fe; k++) begin
      repeat (HALF) @(negedge clk);
      seen[k]    = data_en ? data_out : 1'b1;
      seen_en[k] = data_en;
      dev_clk    = 1'b0;
      if (k < n_fe - 1) begin
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        if (k == 9) dev_data = ack;
      end
    end
  endtask

  task automatic wait_pulse(output int which, output int lat);
    lat = 0;
    while (!byte_sent && !error && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    which = byte_sent ? 1 : (error ? 2 : 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, which, lat;
    logic [10:0] seen, seen_en;

    @(negedge clk);
    check("reset_outputs", {26'd0, outs}, 32'b001000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of SEND
    send(8'h5A);
    wait_inhibit(n, 1'b0);
    device(4, 1'b0, seen, seen_en);
    repeat (5) @(negedge clk);
    check("t1_busy_mid_send", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t1_reset_outputs", {26'd0, outs}, 32'b001000);
    @(negedge clk);
    reset   = 1'b0;
    dev_clk = 1'b1;
    repeat (40) @(negedge clk);
    check("t1_no_pulse", sent_total + err_total, 32'd0);

    // 0xFF with a request poked during inhibit
    send(8'hFF);
    check("t3_busy_after_accept", {31'd0, busy}, 32'd1);
    wait_inhibit(n, 1'b1);
    check("t3_inhibit_cycles", n, INHIBIT);
    device(11, 1'b0, seen, seen_en);
    check("t3_data_seq", {21'd0, seen}, {21'd0, 11'b11111111110});
    check("t3_drive_en", {21'd0, seen_en}, {21'd0, 11'b01111111111});
    wait_pulse(which, lat);
    check("t6_first_done", which, 32'd1);
    @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;

    // 0xF4 requested the cycle after BYTE_SENT
    send(8'hF4);
    check("t6_second_accept", {31'd0, busy}, 32'd1);
    wait_inhibit(n, 1'b0);
    device(11, 1'b0, seen, seen_en);
    check("t2_data_seq", {21'd0, seen}, {21'd0, 11'b10111101000});
    check("t2_drive_en", {21'd0, seen_en}, {21'd0, 11'b01111111111});
    wait_pulse(which, lat);
    check("t2_done", which, 32'd1);
    @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;

    // NACK on the 11th edge
    send(8'hA5);
    wait_inhibit(n, 1'b0);
    device(11, 1'b1, seen, seen_en);
    wait_pulse(which, lat);
    check("t5_nack_error", which, 32'd2);
    @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;

    // Accepted right after ERROR; device never clocks -> timeout
    send(8'h00);
    check("t5_next_accept", {31'd0, busy}, 32'd1);
    wait_inhibit(n, 1'b0);
    wait_pulse(which, lat);
    check("t4_timeout_error", which, 32'd2);
    check("t4_latency", lat, TIMEOUT);
    check("t4_pads_released", {30'd0, clk_en, data_en}, 32'd0);
    repeat (5) @(negedge clk);
    check("pulse_totals", {sent_total[15:0], err_total[15:0]}, {16'd2, 16'd2});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
